// File: rtl/stream_rr_arbiter_pkg.sv
// Shared definitions for the round-robin stream arbiter: FSM encoding and index-width helper.
package stream_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Keeps index vectors at least one bit wide when a parameter collapses to 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Bundle of the NUM_IN upstream valid/ready streams and the single shared downstream stream.
interface stream_rr_arbiter_if #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32
) ();
  localparam int SRC_W = stream_arb_pkg::idx_width(NUM_IN);

  logic [NUM_IN*DATA_WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]            in_valid;
  logic [NUM_IN-1:0]            in_last;
  logic [NUM_IN-1:0]            in_ready;
  logic [DATA_WIDTH-1:0]        out_data;
  logic                         out_valid;
  logic                         out_last;
  logic [SRC_W-1:0]             out_src;
  logic                         out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_src
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_src
  );
endinterface

// File: rtl/stream_rr_arbiter_picker.sv
// Combinational round-robin search: first requester after last_grant, wrapping modulo NUM_IN.
module rr_priority_picker
  import stream_arb_pkg::*;
#(
  parameter int NUM_IN = 4,
  localparam int SRC_W = idx_width(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SRC_W-1:0]  last_grant,
  output logic [SRC_W-1:0]  gnt_idx,
  output logic              gnt_any
);

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    // last_grant itself is searched last, so a lone requester can be re-granted.
    for (int k = 1; k <= NUM_IN; k++) begin
      if (!gnt_any && req[(int'(last_grant) + k) % NUM_IN]) begin
        gnt_any = 1'b1;
        gnt_idx = SRC_W'((int'(last_grant) + k) % NUM_IN);
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one downstream stream between NUM_IN sources, one burst per grant.
// state    | meaning
// ARB_IDLE | bubble cycle: nothing forwarded, next source picked from in_valid
// ARB_BUSY | granted source muxed straight through until last beat or MAX_BURST beats
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input logic                clk,
  input logic                reset,
  stream_rr_arbiter_if.slave bus
);

  localparam int SRC_W = idx_width(NUM_IN);
  localparam int CNT_W = idx_width(MAX_BURST + 1);

  arb_state_e       state;
  logic [SRC_W-1:0] grant;
  logic [SRC_W-1:0] last_grant;
  logic [SRC_W-1:0] pick_idx;
  logic             pick_any;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_nxt;
  logic             beat;
  logic             burst_done;

  rr_priority_picker #(.NUM_IN(NUM_IN)) u_picker (
    .req        (bus.in_valid),
    .last_grant (last_grant),
    .gnt_idx    (pick_idx),
    .gnt_any    (pick_any)
  );

  assign beat       = (state == ARB_BUSY) && bus.in_valid[grant] && bus.out_ready;
  assign burst_nxt  = burst_cnt + CNT_W'(1);
  assign burst_done = bus.in_last[grant] || (burst_nxt == CNT_W'(MAX_BURST));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= SRC_W'(NUM_IN - 1);
      burst_cnt  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant     <= pick_idx;
            burst_cnt <= '0;
            state     <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (beat) begin
            burst_cnt <= burst_nxt;
            if (burst_done) begin
              last_grant <= grant;
              state      <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // in_ready depends only on state, grant and out_ready, never on in_valid.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;
    bus.in_ready  = '0;
    if (state == ARB_BUSY) begin
      bus.out_valid       = bus.in_valid[grant];
      bus.out_last        = bus.in_last[grant];
      bus.out_data        = bus.in_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      bus.in_ready[grant] = bus.out_ready;
    end
  end

  assign bus.out_src = grant;

endmodule
